// File: rtl/css_mcu0_dmi_router_pkg.sv
// Shared widths, default aperture map and FSM encoding for the MCU0 DMI router.
package css_mcu0_dmi_router_pkg;

    localparam int unsigned DMI_AW = 7;
    localparam int unsigned DMI_DW = 32;

    // Target 0 = core debug module, target 1 = uncore register blocks.
    localparam logic [2*DMI_AW-1:0] DEF_TGT_LO = {7'h50, 7'h00};
    localparam logic [2*DMI_AW-1:0] DEF_TGT_HI = {7'h7F, 7'h4F};

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD
    } state_t;

endpackage

// File: rtl/css_mcu0_dmi_router_dec.sv
// Combinational aperture decoder: one-hot select of the lowest-index matching target.
module css_mcu0_dmi_router_dec
    import css_mcu0_dmi_router_pkg::*;
#(
    parameter int unsigned               N_TGT  = 2,
    parameter logic [N_TGT*DMI_AW-1:0]   TGT_LO = DEF_TGT_LO,
    parameter logic [N_TGT*DMI_AW-1:0]   TGT_HI = DEF_TGT_HI
) (
    input  logic [DMI_AW-1:0] addr,
    output logic [N_TGT-1:0]  sel,
    output logic              unmapped
);

    logic found;

    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_TGT; i++) begin
            if (!found &&
                (addr >= TGT_LO[i*DMI_AW +: DMI_AW]) &&
                (addr <= TGT_HI[i*DMI_AW +: DMI_AW])) begin
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    assign unmapped = ~found;

endmodule

// File: rtl/css_mcu0_dmi_router.sv
// Registered DMI aperture router with fixed-latency read capture and busy flag.
// Optional saturating error counter enabled by CSS_MCU0_DMI_ROUTER_ERR_CNT_EN.
module css_mcu0_dmi_router
    import css_mcu0_dmi_router_pkg::*;
#(
    parameter int unsigned               N_TGT     = 2,
    parameter logic [N_TGT*DMI_AW-1:0]   TGT_LO    = DEF_TGT_LO,
    parameter logic [N_TGT*DMI_AW-1:0]   TGT_HI    = DEF_TGT_HI,
    parameter int unsigned               RD_LAT    = 1,
    parameter int unsigned               ERR_CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_TGT-1:0]          tgt_enable,
    input  logic                      dmi_en,
    input  logic                      dmi_wr_en,
    input  logic [DMI_AW-1:0]         dmi_addr,
    input  logic [DMI_DW-1:0]         dmi_wdata,
    output logic [DMI_DW-1:0]         dmi_rdata,
    output logic                      dmi_busy,
    output logic [N_TGT-1:0]          dmi_tgt_en,
    output logic [N_TGT-1:0]          dmi_tgt_wr_en,
    output logic [DMI_AW-1:0]         dmi_tgt_addr,
    output logic [DMI_DW-1:0]         dmi_tgt_wdata,
    input  logic [N_TGT*DMI_DW-1:0]   dmi_tgt_rdata,
    input  logic                      err_cnt_clr,
    output logic [ERR_CNT_W-1:0]      err_cnt
);

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          lat_cnt;
    logic                accept;
    logic                capture;
    logic                err_evt;
    logic [N_TGT-1:0]    sel;
    logic                unmapped;
    logic [N_TGT-1:0]    fwd_sel;
    logic [N_TGT-1:0]    rd_sel_q;
    logic [N_TGT-1:0]    tgt_en_q;
    logic [N_TGT-1:0]    tgt_wr_q;
    logic [DMI_AW-1:0]   addr_q;
    logic [DMI_DW-1:0]   wdata_q;
    logic [DMI_DW-1:0]   rdata_q;
    logic [DMI_DW-1:0]   cap_data;

    css_mcu0_dmi_router_dec #(
        .N_TGT  (N_TGT),
        .TGT_LO (TGT_LO),
        .TGT_HI (TGT_HI)
    ) u_dec (
        .addr     (dmi_addr),
        .sel      (sel),
        .unmapped (unmapped)
    );

    // Enable is sampled here, at accept; the captured select drives the read mux.
    assign fwd_sel = sel & tgt_enable;
    assign accept  = dmi_en && (state == IDLE);
    assign err_evt = (accept && (unmapped || (fwd_sel == '0))) ||
                     (dmi_en && (state != IDLE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (dmi_en) state_nxt = dmi_wr_en ? WR : RD;
            WR:      state_nxt = IDLE;
            RD:      if (lat_cnt == LAT_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dmi_busy = (state != IDLE);
        capture  = (state == RD) && (lat_cnt == LAT_LAST);
    end

    always_comb begin
        cap_data = '0;
        for (int unsigned i = 0; i < N_TGT; i++) begin
            if (rd_sel_q[i]) cap_data = cap_data | dmi_tgt_rdata[i*DMI_DW +: DMI_DW];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt  <= '0;
            rd_sel_q <= '0;
            tgt_en_q <= '0;
            tgt_wr_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            tgt_en_q <= '0;
            tgt_wr_q <= '0;
            if (accept) begin
                addr_q   <= dmi_addr;
                wdata_q  <= dmi_wdata;
                tgt_en_q <= fwd_sel;
                tgt_wr_q <= dmi_wr_en ? fwd_sel : '0;
                rd_sel_q <= fwd_sel;
                lat_cnt  <= '0;
            end else if (state == RD) begin
                lat_cnt <= lat_cnt + 2'd1;
            end
            if (capture) begin
                rdata_q <= cap_data;
            end
        end
    end

    assign dmi_rdata     = rdata_q;
    assign dmi_tgt_en    = tgt_en_q;
    assign dmi_tgt_wr_en = tgt_wr_q;
    assign dmi_tgt_addr  = addr_q;
    assign dmi_tgt_wdata = wdata_q;

`ifdef CSS_MCU0_DMI_ROUTER_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else if (err_cnt_clr) begin
            err_q <= '0;
        end else if (err_evt && (err_q != '1)) begin
            err_q <= err_q + 1'b1;
        end
    end

    assign err_cnt = err_q;
`else
    logic unused_err;
    assign unused_err = err_cnt_clr ^ err_evt;
    assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_css_mcu0_dmi_router.sv
// Directed bench for css_mcu0_dmi_router: three instances cover default, RD_LAT=3
// overrun, and single-target RD_LAT=4 / 2-bit counter configurations.
module tb_css_mcu0_dmi_router;
    import css_mcu0_dmi_router_pkg::*;

`ifdef CSS_MCU0_DMI_ROUTER_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst;
    logic [2:0]  en;
    logic [2:0]  clr;
    logic        wr;
    logic [6:0]  addr;
    logic [31:0] wdata;

    logic [1:0]  tgt_enable_a, tgt_enable_b;
    logic [0:0]  tgt_enable_c;
    logic [63:0] trd_a, trd_b;
    logic [31:0] trd_c;

    logic [31:0] rdata_a, rdata_b, rdata_c;
    logic        busy_a, busy_b, busy_c;
    logic [1:0]  ten_a, ten_b, twr_a, twr_b;
    logic [0:0]  ten_c, twr_c;
    logic [6:0]  taddr_a, taddr_b, taddr_c;
    logic [31:0] twdata_a, twdata_b, twdata_c;
    logic [7:0]  err_a, err_b;
    logic [1:0]  err_c;

    int total = 0;
    int bad   = 0;

    css_mcu0_dmi_router u_dut_a (
        .clk(clk), .rst(rst[0]), .tgt_enable(tgt_enable_a),
        .dmi_en(en[0]), .dmi_wr_en(wr), .dmi_addr(addr), .dmi_wdata(wdata),
        .dmi_rdata(rdata_a), .dmi_busy(busy_a), .dmi_tgt_en(ten_a), .dmi_tgt_wr_en(twr_a),
        .dmi_tgt_addr(taddr_a), .dmi_tgt_wdata(twdata_a), .dmi_tgt_rdata(trd_a),
        .err_cnt_clr(clr[0]), .err_cnt(err_a)
    );

    css_mcu0_dmi_router #(.RD_LAT(3)) u_dut_b (
        .clk(clk), .rst(rst[1]), .tgt_enable(tgt_enable_b),
        .dmi_en(en[1]), .dmi_wr_en(wr), .dmi_addr(addr), .dmi_wdata(wdata),
        .dmi_rdata(rdata_b), .dmi_busy(busy_b), .dmi_tgt_en(ten_b), .dmi_tgt_wr_en(twr_b),
        .dmi_tgt_addr(taddr_b), .dmi_tgt_wdata(twdata_b), .dmi_tgt_rdata(trd_b),
        .err_cnt_clr(clr[1]), .err_cnt(err_b)
    );

    css_mcu0_dmi_router #(
        .N_TGT(1), .TGT_LO(7'h00), .TGT_HI(7'h3F), .RD_LAT(4), .ERR_CNT_W(2)
    ) u_dut_c (
        .clk(clk), .rst(rst[2]), .tgt_enable(tgt_enable_c),
        .dmi_en(en[2]), .dmi_wr_en(wr), .dmi_addr(addr), .dmi_wdata(wdata),
        .dmi_rdata(rdata_c), .dmi_busy(busy_c), .dmi_tgt_en(ten_c), .dmi_tgt_wr_en(twr_c),
        .dmi_tgt_addr(taddr_c), .dmi_tgt_wdata(twdata_c), .dmi_tgt_rdata(trd_c),
        .err_cnt_clr(clr[2]), .err_cnt(err_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; holds dmi_en across one posedge, returns at the next negedge.
    task automatic issue(input int k, input logic w, input logic [6:0] a, input logic [31:0] d);
        en[k] = 1'b1;
        wr    = w;
        addr  = a;
        wdata = d;
        @(negedge clk);
        en[k] = 1'b0;
    endtask

    initial begin
        rst = '1; en = '0; clr = '0; wr = 1'b0; addr = '0; wdata = '0;
        tgt_enable_a = 2'b11; tgt_enable_b = 2'b11; tgt_enable_c = 1'b1;
        trd_a = {32'hBEEF_0002, 32'hCAFE_0001};
        trd_b = {32'h5A5A_0004, 32'hA5A5_0003};
        trd_c = 32'h1111_2222;
        repeat (3) @(negedge clk);
        rst = '0;

        check("rst_rdata", rdata_a, 32'h0);
        check("rst_busy", {31'b0, busy_a}, 32'h0);
        check("rst_tgt_en", {30'b0, ten_a}, 32'h0);
        check("rst_tgt_wr", {30'b0, twr_a}, 32'h0);
        check("rst_addr", {25'b0, taddr_a}, 32'h0);
        check("rst_wdata", twdata_a, 32'h0);
        check("rst_err", {24'b0, err_a}, 32'h0);

        // core read, RD_LAT=1
        issue(0, 1'b0, 7'h10, 32'h0);
        check("crd_tgt_en", {30'b0, ten_a}, 32'h1);
        check("crd_tgt_wr", {30'b0, twr_a}, 32'h0);
        check("crd_busy", {31'b0, busy_a}, 32'h1);
        check("crd_addr", {25'b0, taddr_a}, 32'h10);
        check("crd_rdata_early", rdata_a, 32'h0);
        @(negedge clk);
        check("crd_tgt_en_off", {30'b0, ten_a}, 32'h0);
        check("crd_busy_off", {31'b0, busy_a}, 32'h0);
        check("crd_rdata", rdata_a, 32'hCAFE_0001);

        // uncore write
        issue(0, 1'b1, 7'h50, 32'h1234_5678);
        check("uwr_tgt_wr", {30'b0, twr_a}, 32'h2);
        check("uwr_tgt_en", {30'b0, ten_a}, 32'h2);
        check("uwr_wdata", twdata_a, 32'h1234_5678);
        check("uwr_busy", {31'b0, busy_a}, 32'h1);
        @(negedge clk);
        check("uwr_tgt_wr_off", {30'b0, twr_a}, 32'h0);
        check("uwr_busy_off", {31'b0, busy_a}, 32'h0);
        check("uwr_rdata_kept", rdata_a, 32'hCAFE_0001);
        check("uwr_wdata_kept", twdata_a, 32'h1234_5678);

        // back-to-back read right after write, top of uncore range
        issue(0, 1'b0, 7'h7F, 32'h0);
        check("b2b_tgt_en", {30'b0, ten_a}, 32'h2);
        @(negedge clk);
        check("b2b_rdata", rdata_a, 32'hBEEF_0002);

        // top of core range
        issue(0, 1'b0, 7'h4F, 32'h0);
        check("edge4f_tgt_en", {30'b0, ten_a}, 32'h1);
        @(negedge clk);
        check("edge4f_rdata", rdata_a, 32'hCAFE_0001);

        // disabled target
        tgt_enable_a = 2'b01;
        issue(0, 1'b0, 7'h60, 32'h0);
        check("dis_tgt_en", {30'b0, ten_a}, 32'h0);
        check("dis_busy", {31'b0, busy_a}, 32'h1);
        @(negedge clk);
        check("dis_rdata", rdata_a, 32'h0);
        check("dis_err", {24'b0, err_a}, ERR_EN ? 32'd1 : 32'd0);
        issue(0, 1'b1, 7'h70, 32'hFFFF_0000);
        check("dis_wr_tgt_wr", {30'b0, twr_a}, 32'h0);
        @(negedge clk);
        check("dis_wr_err", {24'b0, err_a}, ERR_EN ? 32'd2 : 32'd0);
        check("dis_wr_rdata", rdata_a, 32'h0);
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        check("clr_err", {24'b0, err_a}, 32'h0);

        // overrun on RD_LAT=3, enable dropped mid-read
        issue(1, 1'b0, 7'h00, 32'h0);
        check("ovr_tgt_en", {30'b0, ten_b}, 32'h1);
        check("ovr_busy1", {31'b0, busy_b}, 32'h1);
        tgt_enable_b = 2'b00;
        @(negedge clk);
        check("ovr_tgt_en_off", {30'b0, ten_b}, 32'h0);
        check("ovr_busy2", {31'b0, busy_b}, 32'h1);
        en[1] = 1'b1;
        addr  = 7'h50;
        @(negedge clk);
        en[1] = 1'b0;
        check("ovr_dropped", {30'b0, ten_b}, 32'h0);
        check("ovr_busy3", {31'b0, busy_b}, 32'h1);
        check("ovr_err", {24'b0, err_b}, ERR_EN ? 32'd1 : 32'd0);
        @(negedge clk);
        check("ovr_busy_off", {31'b0, busy_b}, 32'h0);
        check("ovr_rdata", rdata_b, 32'hA5A5_0003);
        check("ovr_err_hold", {24'b0, err_b}, ERR_EN ? 32'd1 : 32'd0);
        tgt_enable_b = 2'b11;
        issue(1, 1'b0, 7'h50, 32'h0);
        check("ovr_next_tgt_en", {30'b0, ten_b}, 32'h2);
        repeat (2) @(negedge clk);
        check("ovr_next_rdata_early", rdata_b, 32'hA5A5_0003);
        @(negedge clk);
        check("ovr_next_rdata", rdata_b, 32'h5A5A_0004);

        // saturation with 2-bit counter, single target, RD_LAT=4
        for (int i = 0; i < 5; i++) begin
            issue(2, 1'b0, 7'h70, 32'h0);
            check("sat_tgt_en", {31'b0, ten_c}, 32'h0);
            repeat (4) @(negedge clk);
        end
        check("sat_err", {30'b0, err_c}, ERR_EN ? 32'd3 : 32'd0);
        check("sat_rdata", rdata_c, 32'h0);
        clr[2] = 1'b1;
        issue(2, 1'b0, 7'h70, 32'h0);
        clr[2] = 1'b0;
        check("clr_prio_err", {30'b0, err_c}, 32'h0);
        repeat (4) @(negedge clk);
        check("clr_prio_err_hold", {30'b0, err_c}, 32'h0);

        // mapped read, then reset mid-read
        issue(2, 1'b0, 7'h20, 32'h0);
        check("c_rd_tgt_en", {31'b0, ten_c}, 32'h1);
        repeat (3) @(negedge clk);
        check("c_rd_busy4", {31'b0, busy_c}, 32'h1);
        @(negedge clk);
        check("c_rd_busy_off", {31'b0, busy_c}, 32'h0);
        check("c_rd_rdata", rdata_c, 32'h1111_2222);
        trd_c = 32'h3333_4444;
        issue(2, 1'b0, 7'h21, 32'h0);
        @(negedge clk);
        rst[2] = 1'b1;
        #1;
        check("mrst_busy", {31'b0, busy_c}, 32'h0);
        check("mrst_rdata", rdata_c, 32'h0);
        check("mrst_addr", {25'b0, taddr_c}, 32'h0);
        @(negedge clk);
        rst[2] = 1'b0;
        issue(2, 1'b0, 7'h22, 32'h0);
        check("post_rst_tgt_en", {31'b0, ten_c}, 32'h1);
        check("post_rst_addr", {25'b0, taddr_c}, 32'h22);
        repeat (3) @(negedge clk);
        check("post_rst_busy4", {31'b0, busy_c}, 32'h1);
        check("post_rst_rdata_early", rdata_c, 32'h0);
        @(negedge clk);
        check("post_rst_busy_off", {31'b0, busy_c}, 32'h0);
        check("post_rst_rdata", rdata_c, 32'h3333_4444);
        check("post_rst_err", {30'b0, err_c}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
